// File: rtl/lpm_tbl_access.sv
// Host-side AXI4-Lite register front end for the LPM table request/ack port.
// Converts CMD writes into one-cycle table requests, waits for the ack with a timeout, and keeps read data for the host.
module lpm_tbl_access #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_TBL_ADDR_WIDTH   = 5,
  parameter int C_ACK_TIMEOUT      = 16
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              tbl_wr_req,
  output logic                              tbl_rd_req,
  output logic [C_TBL_ADDR_WIDTH-1:0]       tbl_wr_addr,
  output logic [C_TBL_ADDR_WIDTH-1:0]       tbl_rd_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data,
  input  logic                              tbl_wr_ack,
  input  logic                              tbl_rd_ack
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int TA = C_TBL_ADDR_WIDTH;
  localparam int TW = $clog2(C_ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic            op_wr_q, op_wr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   wr_data_q [4];
  logic [DW-1:0]   wr_data_d [4];
  logic [DW-1:0]   rd_data_q [4];
  logic [DW-1:0]   rd_data_d [4];
  logic [TA-1:0]   addr_q, addr_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            dropped_q, dropped_d;
  logic [31:0]     to_cnt_q, to_cnt_d;
  logic            awready_q, awready_d;
  logic            bvalid_q, bvalid_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            wr_hs, rd_hs, busy, cmd_wr, cmd_go, ack_hit;
  logic [3:0]      wr_idx, rd_idx;
  logic            unused_bits;

  assign wr_hs   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs   = arready_q & S_AXI_ARVALID;
  assign wr_idx  = S_AXI_AWADDR[5:2];
  assign rd_idx  = S_AXI_ARADDR[5:2];
  assign busy    = (state_q != S_IDLE);
  assign cmd_wr  = wr_hs && (wr_idx == 4'd9);
  assign cmd_go  = (S_AXI_WDATA == DW'(1)) || (S_AXI_WDATA == DW'(2));
  assign ack_hit = op_wr_q ? tbl_wr_ack : tbl_rd_ack;

  assign unused_bits = ^{S_AXI_AWADDR[AW-1:6], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[AW-1:6], S_AXI_ARADDR[1:0], S_AXI_WSTRB};

  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    timer_d   = timer_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    addr_d    = addr_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    dropped_d = dropped_q;
    to_cnt_d  = to_cnt_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;

    // Ready is a one-cycle registered pulse, so reset leaves every handshake output low.
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;

    if (wr_hs) begin
      bvalid_d = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      case (rd_idx)
        4'd0, 4'd1, 4'd2, 4'd3: rdata_d = wr_data_q[rd_idx[1:0]];
        4'd4, 4'd5, 4'd6, 4'd7: rdata_d = rd_data_q[rd_idx[1:0]];
        4'd8:  rdata_d[TA-1:0] = addr_q;
        4'd10: rdata_d[3:0]    = {dropped_q, timeout_q, done_q, busy};
        4'd11: rdata_d[31:0]   = to_cnt_q;
        default: rdata_d = '0;
      endcase
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    if (wr_hs) begin
      case (wr_idx)
        4'd0, 4'd1, 4'd2, 4'd3: wr_data_d[wr_idx[1:0]] = S_AXI_WDATA;
        4'd8: addr_d = S_AXI_WDATA[TA-1:0];
        4'd10: begin
          if (S_AXI_WDATA[1]) done_d    = 1'b0;
          if (S_AXI_WDATA[2]) timeout_d = 1'b0;
          if (S_AXI_WDATA[3]) dropped_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Hardware status updates come after the W1C decode so a coincident set wins.
    case (state_q)
      S_IDLE: begin
        if (cmd_wr && cmd_go) begin
          state_d   = S_REQ;
          op_wr_d   = (S_AXI_WDATA == DW'(1));
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        timer_d = TW'(C_ACK_TIMEOUT);
      end
      S_WAIT: begin
        if (ack_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!op_wr_q) begin
            for (int i = 0; i < 4; i++) rd_data_d[i] = tbl_rd_data[i*DW +: DW];
          end
        end else if (timer_q <= TW'(1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          if (to_cnt_q != 32'hFFFF_FFFF) to_cnt_d = to_cnt_q + 32'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_wr && busy) dropped_d = 1'b1;
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q   <= S_IDLE;
      op_wr_q   <= 1'b0;
      timer_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        wr_data_q[i] <= '0;
        rd_data_q[i] <= '0;
      end
      addr_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      dropped_q <= 1'b0;
      to_cnt_q  <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      timer_q   <= timer_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      dropped_q <= dropped_d;
      to_cnt_q  <= to_cnt_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  assign tbl_wr_req  = (state_q == S_REQ) &  op_wr_q;
  assign tbl_rd_req  = (state_q == S_REQ) & ~op_wr_q;
  assign tbl_wr_addr = addr_q;
  assign tbl_rd_addr = addr_q;
  assign tbl_wr_data = {wr_data_q[3], wr_data_q[2], wr_data_q[1], wr_data_q[0]};

endmodule
